// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin sharing of one LCD1602 bus among
// NUM_REQ writers, with setup/enable/hold timing and execution wait.
module lcd_bus_arbiter #(
   parameter int NUM_REQ          = 3,
   parameter int SETUP_CYCLES     = 2,
   parameter int EN_CYCLES        = 4,
   parameter int HOLD_CYCLES      = 2,
   parameter int WAIT_CYCLES      = 10,
   parameter int LONG_WAIT_CYCLES = 40
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         req_rs,
   input  logic [8*NUM_REQ-1:0]       req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       lcd_rs,
   output logic                       lcd_rw,
   output logic                       lcd_enable,
   output logic [7:0]                 lcd_data
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int MAX_A =
      (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
   localparam int MAX_B =
      (HOLD_CYCLES > WAIT_CYCLES) ? HOLD_CYCLES : WAIT_CYCLES;
   localparam int MAX_C =
      (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC =
      (MAX_C > LONG_WAIT_CYCLES) ? MAX_C : LONG_WAIT_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ENABLE,
      HOLD,
      EXEC_WAIT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [ID_W-1:0]   last;
   logic              found;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   idx_w;
   int                idx;
   logic              long_cmd;

   assign lcd_rw = 1'b0;

   // clear/home commands need the long execution wait
   assign long_cmd = !lcd_rs &&
                     (lcd_data == 8'h01 ||
                      lcd_data == 8'h02 ||
                      lcd_data == 8'h03);

   // round-robin search starting just after the last grant
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_w  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx   = (int'(last) + 1 + i) % NUM_REQ;
         idx_w = ID_W'(idx);
         if (!found && req[idx_w]) begin
            found  = 1'b1;
            winner = idx_w;
         end
      end
   end

   // bus FSM: grant, timed strobe phases, execution wait
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         last       <= ID_W'(NUM_REQ - 1);
         ack        <= '0;
         done       <= '0;
         busy       <= 1'b0;
         lcd_enable <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         grant_id   <= '0;
      end else begin
         ack  <= '0;
         done <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state    <= SETUP;
                  cnt      <= CNT_W'(SETUP_CYCLES - 1);
                  busy     <= 1'b1;
                  grant_id <= winner;
                  last     <= winner;
                  ack      <= NUM_REQ'(1) << winner;
                  lcd_rs   <= req_rs[winner];
                  lcd_data <= req_data[{winner, 3'b000} +: 8];
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state      <= ENABLE;
                  cnt        <= CNT_W'(EN_CYCLES - 1);
                  lcd_enable <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ENABLE: begin
               if (cnt == '0) begin
                  state      <= HOLD;
                  cnt        <= CNT_W'(HOLD_CYCLES - 1);
                  lcd_enable <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state <= EXEC_WAIT;
                  cnt   <= long_cmd ?
                           CNT_W'(LONG_WAIT_CYCLES - 1) :
                           CNT_W'(WAIT_CYCLES - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            EXEC_WAIT: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= NUM_REQ'(1) << grant_id;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: scoreboard bench for lcd_bus_arbiter
// with default timing parameters and three requesters.
module tb_lcd_bus_arbiter;

   localparam int N = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   req_rs = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic [N-1:0]   done;
   logic           busy;
   logic [1:0]     grant_id;
   logic           lcd_rs;
   logic           lcd_rw;
   logic           lcd_enable;
   logic [7:0]     lcd_data;

   int pass_cnt = 0;
   int total = 0;
   int cyc = 0;

   typedef struct {
      int         id;
      int         lat;
      logic       rs;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      int         ida;
      int         ta;
      int         gid;
      int         idd;
      int         td;
      int         enc;
      int         fen;
      int         uns;
      int         xa;
      logic       rs0;
      logic [7:0] d0;
      logic       bsd;
   } obs_t;

   exp_t sb[$];

   lcd_bus_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_rs     (req_rs),
      .req_data   (req_data),
      .ack        (ack),
      .done       (done),
      .busy       (busy),
      .grant_id   (grant_id),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_enable (lcd_enable),
      .lcd_data   (lcd_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic int onehot_idx(input logic [N-1:0] v);
      int id;
      int n;
      id = -1;
      n = 0;
      for (int i = 0; i < N; i++) begin
         if (v[i] === 1'b1) begin
            id = i;
            n++;
         end
      end
      if (n > 1) id = -2;
      return id;
   endfunction

   task automatic observe_xfer(input logic [N-1:0] mask,
                               output obs_t o);
      o = '{-1, 0, -1, -1, 0, 0, -1, 0, 0, 1'b0, 8'h00, 1'bx};
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ack != '0) begin
            o.ida = onehot_idx(ack);
            o.ta  = cyc;
            o.gid = int'(grant_id);
            o.rs0 = lcd_rs;
            o.d0  = lcd_data;
            break;
         end
      end
      if (o.ida < 0) return;
      req = req & ~mask;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (ack != '0) o.xa++;
         if (lcd_enable === 1'b1) begin
            if (o.fen < 0) o.fen = cyc;
            o.enc++;
         end
         if (lcd_rs !== o.rs0 || lcd_data !== o.d0) o.uns++;
         if (done != '0) begin
            o.idd = onehot_idx(done);
            o.td  = cyc;
            o.bsd = busy;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || ack !== '0 || done !== '0)
         $display("FAIL reset_ctl: busy=%b ack=%b done=%b want 0",
                  busy, ack, done);
      else pass_cnt++;
      total++;
      if (lcd_enable !== 1'b0 || lcd_rw !== 1'b0 || lcd_rs !== 1'b0)
         $display("FAIL reset_lcd: en=%b rw=%b rs=%b want 0",
                  lcd_enable, lcd_rw, lcd_rs);
      else pass_cnt++;
      total++;
      if (lcd_data !== 8'h00 || grant_id !== 2'd0)
         $display("FAIL reset_bus: data=%h gid=%0d want 00/0",
                  lcd_data, grant_id);
      else pass_cnt++;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0)
         $display("FAIL idle_busy: got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      obs_t o;
      exp_t e;
      req_rs[0] = 1'b1;
      req_data[7:0] = 8'h35;
      req[0] = 1'b1;
      sb.push_back('{0, 18, 1'b1, 8'h35});
      observe_xfer(3'b111, o);
      e = sb.pop_front();
      total++;
      if (o.ida !== e.id || o.gid !== e.id)
         $display("FAIL single_ack: ack=%0d gid=%0d want %0d",
                  o.ida, o.gid, e.id);
      else pass_cnt++;
      total++;
      if (o.rs0 !== e.rs || o.d0 !== e.data)
         $display("FAIL single_bus: rs=%b data=%h want %b/%h",
                  o.rs0, o.d0, e.rs, e.data);
      else pass_cnt++;
      total++;
      if (o.fen - o.ta !== 2 || o.enc !== 4)
         $display("FAIL single_en: start=%0d len=%0d want 2/4",
                  o.fen - o.ta, o.enc);
      else pass_cnt++;
      total++;
      if (o.idd !== e.id || o.td - o.ta !== e.lat)
         $display("FAIL single_done: id=%0d lat=%0d want %0d/%0d",
                  o.idd, o.td - o.ta, e.id, e.lat);
      else pass_cnt++;
      total++;
      if (o.uns !== 0 || o.xa !== 0 || o.bsd !== 1'b0)
         $display("FAIL single_misc: uns=%0d xa=%0d busy=%b want 0",
                  o.uns, o.xa, o.bsd);
      else pass_cnt++;
   endtask

   task automatic test_long_wait();
      obs_t o;
      exp_t e;
      logic [7:0] dt[2] = '{8'h01, 8'h38};
      int lt[2] = '{48, 18};
      for (int k = 0; k < 2; k++) begin
         req_rs[0] = 1'b0;
         req_data[7:0] = dt[k];
         req[0] = 1'b1;
         sb.push_back('{0, lt[k], 1'b0, dt[k]});
         observe_xfer(3'b001, o);
         e = sb.pop_front();
         total++;
         if (o.ida !== e.id || o.idd !== e.id || o.td - o.ta !== e.lat)
            $display("FAIL wait_%h: ack=%0d done=%0d lat=%0d want %0d",
                     e.data, o.ida, o.idd, o.td - o.ta, e.lat);
         else pass_cnt++;
         total++;
         if (o.d0 !== e.data || o.rs0 !== e.rs || o.uns !== 0)
            $display("FAIL wait_bus_%h: data=%h rs=%b uns=%0d",
                     e.data, o.d0, o.rs0, o.uns);
         else pass_cnt++;
      end
   endtask

   task automatic test_round_robin();
      obs_t o;
      exp_t e;
      int prev_td;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      req_rs = 3'b011;
      req_data = {8'h01, 8'h42, 8'h41};
      req = 3'b111;
      sb.push_back('{0, 18, 1'b1, 8'h41});
      sb.push_back('{1, 18, 1'b1, 8'h42});
      sb.push_back('{2, 48, 1'b0, 8'h01});
      sb.push_back('{0, 18, 1'b1, 8'h41});
      prev_td = 0;
      for (int k = 0; k < 4; k++) begin
         observe_xfer((k == 3) ? 3'b111 : 3'b000, o);
         e = sb.pop_front();
         total++;
         if (o.ida !== e.id || o.d0 !== e.data || o.rs0 !== e.rs)
            $display("FAIL rr_grant%0d: id=%0d data=%h want %0d/%h",
                     k, o.ida, o.d0, e.id, e.data);
         else pass_cnt++;
         total++;
         if (o.idd !== e.id || o.td - o.ta !== e.lat || o.xa !== 0)
            $display("FAIL rr_done%0d: id=%0d lat=%0d xa=%0d want %0d",
                     k, o.idd, o.td - o.ta, o.xa, e.lat);
         else pass_cnt++;
         if (k > 0) begin
            total++;
            if (o.ta - prev_td !== 1)
               $display("FAIL rr_gap%0d: got %0d want 1",
                        k, o.ta - prev_td);
            else pass_cnt++;
         end
         prev_td = o.td;
      end
   endtask

   task automatic test_ignore_busy();
      obs_t o;
      exp_t e;
      int prev_td;
      req = '0;
      req_rs = 3'b011;
      req_data = {8'h01, 8'h42, 8'h41};
      req[0] = 1'b1;
      sb.push_back('{0, 18, 1'b1, 8'h41});
      sb.push_back('{1, 18, 1'b1, 8'h42});
      sb.push_back('{2, 48, 1'b0, 8'h01});
      fork
         observe_xfer(3'b001, o);
         begin
            repeat (4) @(negedge clk);
            req[2:1] = 2'b11;
         end
      join
      e = sb.pop_front();
      total++;
      if (o.ida !== e.id || o.xa !== 0 || o.uns !== 0)
         $display("FAIL busy_first: id=%0d xa=%0d uns=%0d want %0d",
                  o.ida, o.xa, o.uns, e.id);
      else pass_cnt++;
      prev_td = o.td;
      for (int k = 0; k < 2; k++) begin
         observe_xfer((k == 0) ? 3'b010 : 3'b100, o);
         e = sb.pop_front();
         total++;
         if (o.ida !== e.id || o.d0 !== e.data || o.ta - prev_td !== 1)
            $display("FAIL busy_next%0d: id=%0d data=%h gap=%0d want %0d",
                     k, o.ida, o.d0, o.ta - prev_td, e.id);
         else pass_cnt++;
         prev_td = o.td;
      end
   endtask

   task automatic test_reset_abort();
      obs_t o;
      exp_t e;
      int seen_ack;
      int seen_en;
      int dn;
      int cr;
      seen_ack = 0;
      seen_en = 0;
      dn = 0;
      req_rs[0] = 1'b1;
      req_data[7:0] = 8'h41;
      req = 3'b001;
      for (int i = 0; i < 50 && seen_ack == 0; i++) begin
         @(negedge clk);
         if (ack[0] === 1'b1) seen_ack = 1;
      end
      req = '0;
      for (int i = 0; i < 50 && seen_en == 0; i++) begin
         @(negedge clk);
         if (lcd_enable === 1'b1) seen_en = 1;
      end
      total++;
      if (seen_en !== 1)
         $display("FAIL abort_enable: seen=%0d want 1", seen_en);
      else pass_cnt++;
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (lcd_enable !== 1'b0 || busy !== 1'b0 || lcd_data !== 8'h00)
         $display("FAIL abort_async: en=%b busy=%b data=%h want 0",
                  lcd_enable, busy, lcd_data);
      else pass_cnt++;
      req_rs[1] = 1'b1;
      req_data[15:8] = 8'h5A;
      req = 3'b010;
      repeat (3) begin
         @(negedge clk);
         if (done != '0 || ack != '0) dn++;
      end
      reset = 1'b1;
      cr = cyc;
      sb.push_back('{1, 18, 1'b1, 8'h5A});
      observe_xfer(3'b010, o);
      e = sb.pop_front();
      total++;
      if (o.ida !== e.id || o.ta - cr !== 1 || o.d0 !== e.data)
         $display("FAIL abort_regrant: id=%0d at=%0d data=%h want %0d/1",
                  o.ida, o.ta - cr, o.d0, e.id);
      else pass_cnt++;
      total++;
      if (dn !== 0 || o.idd !== e.id || o.td - o.ta !== e.lat)
         $display("FAIL abort_done: stray=%0d id=%0d lat=%0d want 0/%0d",
                  dn, o.idd, o.td - o.ta, e.id);
      else pass_cnt++;
   endtask

   task automatic test_withdrawn();
      obs_t o;
      exp_t e;
      int na;
      na = 0;
      req_rs[2] = 1'b1;
      req_data[23:16] = 8'h33;
      req = 3'b100;
      sb.push_back('{2, 18, 1'b1, 8'h33});
      fork
         observe_xfer(3'b100, o);
         begin
            repeat (3) @(negedge clk);
            req_rs[0] = 1'b0;
            req_data[7:0] = 8'hEE;
            req[0] = 1'b1;
            repeat (3) @(negedge clk);
            req[0] = 1'b0;
         end
      join
      e = sb.pop_front();
      total++;
      if (o.ida !== e.id || o.xa !== 0 || o.uns !== 0 || o.d0 !== e.data)
         $display("FAIL wd_xfer: id=%0d xa=%0d uns=%0d data=%h",
                  o.ida, o.xa, o.uns, o.d0);
      else pass_cnt++;
      repeat (30) begin
         @(negedge clk);
         if (ack != '0) na++;
      end
      total++;
      if (na !== 0 || lcd_data !== 8'h33 || lcd_rs !== 1'b1)
         $display("FAIL wd_idle: acks=%0d data=%h rs=%b want 0/33/1",
                  na, lcd_data, lcd_rs);
      else pass_cnt++;
      req_rs[1] = 1'b1;
      req_data[15:8] = 8'h77;
      req = 3'b010;
      sb.push_back('{1, 18, 1'b1, 8'h77});
      observe_xfer(3'b010, o);
      e = sb.pop_front();
      total++;
      if (o.ida !== e.id || o.d0 !== e.data || o.idd !== e.id)
         $display("FAIL wd_legit: id=%0d data=%h done=%0d want %0d/%h",
                  o.ida, o.d0, o.idd, e.id, e.data);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_long_wait();
      test_round_robin();
      test_ignore_busy();
      test_reset_abort();
      test_withdrawn();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
